// File: rtl/frame_readout.sv
// frame_readout
//   Consumer side of the frame data generator. The generator fills a
//   256 x 32-bit frame buffer and then toggles handshakeFPGA. This block
//   streams the frame to the PC link as SYNC0, SYNC1, 1024 data bytes
//   (each word MSB first) and an XOR checksum of the data bytes. It then
//   toggles handshakePC back to release the buffer.
//
// Ports
//   clk, rst_n      : system clock (rising edge), asynchronous active-low reset
//   we/address/data : buffer write port, always honoured
//   handshakeFPGA   : frame-ready toggle from the generator
//   handshakePC     : frame-consumed toggle back to the generator
//   tx_data/tx_valid/tx_ready : byte stream toward the PC link
//   busy            : readout in progress (state other than IDLE)
//   overrun         : sticky, a buffer write arrived while busy
//   frame_count     : completed frames, wraps at 16'hFFFF
module frame_readout #(
  parameter logic [7:0] SYNC0 = 8'hA5,
  parameter logic [7:0] SYNC1 = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] data,
  input  logic        handshakeFPGA,
  output logic        handshakePC,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] frame_count
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR0 = 3'd1;
  localparam logic [2:0] ST_HDR1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic [31:0] mem_r [0:255];
  logic [31:0] rd_data_r;     // prefetched next word
  logic [31:0] word_r;        // word currently being serialised
  logic [7:0]  word_idx_r;
  logic [1:0]  byte_idx_r;
  logic [7:0]  csum_r;
  logic [2:0]  state_r;
  logic        handshake_pc_r;
  logic [7:0]  tx_data_r;
  logic        tx_valid_r;
  logic        busy_r;
  logic        overrun_r;
  logic [15:0] frame_count_r;

  logic        accept_s;
  logic        frame_ready_s;
  logic        rd_en_s;
  logic [7:0]  rd_addr_s;

  // Byte select within a word, index 0 is the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
  endfunction

  assign accept_s      = tx_valid_r & tx_ready;
  assign frame_ready_s = (handshakeFPGA != handshake_pc_r);

  assign handshakePC = handshake_pc_r;
  assign tx_data     = tx_data_r;
  assign tx_valid    = tx_valid_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;
  assign frame_count = frame_count_r;

  // Buffer read control: word 0 on frame start, word 1 when the header
  // finishes, then word w+2 whenever word w+1 moves into word_r.
  always_comb begin
    rd_en_s   = 1'b0;
    rd_addr_s = 8'd0;
    case (state_r)
      ST_IDLE: begin
        rd_en_s   = frame_ready_s;
        rd_addr_s = 8'd0;
      end
      ST_HDR1: begin
        rd_en_s   = accept_s;
        rd_addr_s = 8'd1;
      end
      ST_DATA: begin
        if (accept_s && (byte_idx_r == 2'd3)) begin
          rd_en_s   = 1'b1;
          rd_addr_s = word_idx_r + 8'd2;
        end else begin
          rd_en_s   = 1'b0;
          rd_addr_s = 8'd0;
        end
      end
      default: begin
        rd_en_s   = 1'b0;
        rd_addr_s = 8'd0;
      end
    endcase
  end

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[address] <= data;
    end
  end

  // Synchronous buffer read, holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= 32'd0;
    end else if (rd_en_s) begin
      rd_data_r <= mem_r[rd_addr_s];
    end
  end

  // Readout state machine with registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      handshake_pc_r <= 1'b0;
      tx_data_r      <= 8'h00;
      tx_valid_r     <= 1'b0;
      busy_r         <= 1'b0;
      frame_count_r  <= 16'd0;
      csum_r         <= 8'h00;
      word_r         <= 32'd0;
      word_idx_r     <= 8'd0;
      byte_idx_r     <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (frame_ready_s) begin
            state_r    <= ST_HDR0;
            busy_r     <= 1'b1;
            tx_valid_r <= 1'b1;
            tx_data_r  <= SYNC0;
            csum_r     <= 8'h00;
            word_idx_r <= 8'd0;
            byte_idx_r <= 2'd0;
          end
        end
        ST_HDR0: begin
          if (accept_s) begin
            tx_data_r <= SYNC1;
            state_r   <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (accept_s) begin
            word_r     <= rd_data_r;
            tx_data_r  <= rd_data_r[31:24];
            word_idx_r <= 8'd0;
            byte_idx_r <= 2'd0;
            state_r    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            csum_r <= csum_r ^ tx_data_r;
            if (byte_idx_r != 2'd3) begin
              byte_idx_r <= byte_idx_r + 2'd1;
              tx_data_r  <= byte_sel(word_r, byte_idx_r + 2'd1);
            end else if (word_idx_r == 8'd255) begin
              // Fold in the final data byte while moving to the checksum.
              tx_data_r <= csum_r ^ tx_data_r;
              state_r   <= ST_CSUM;
            end else begin
              word_idx_r <= word_idx_r + 8'd1;
              byte_idx_r <= 2'd0;
              word_r     <= rd_data_r;
              tx_data_r  <= rd_data_r[31:24];
            end
          end
        end
        ST_CSUM: begin
          if (accept_s) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Copy rather than invert, so extra toggles during readout collapse.
          handshake_pc_r <= handshakeFPGA;
          frame_count_r  <= frame_count_r + 16'd1;
          busy_r         <= 1'b0;
          state_r        <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          tx_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag: a buffer write while a readout is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (we && busy_r) begin
      overrun_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_readout.sv
module tb_frame_readout;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [7:0]  address;
  logic [31:0] data;
  logic        handshakeFPGA;
  logic        handshakePC;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;
  logic [15:0] frame_count;

  frame_readout #(.SYNC0(SYNC0), .SYNC1(SYNC1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .address(address), .data(data),
    .handshakeFPGA(handshakeFPGA), .handshakePC(handshakePC),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .frame_count(frame_count)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          bytes_seen = 0;
  int          last_acc_edge = 0;
  logic [7:0]  last_byte = 8'h00;
  logic        mon_en = 1'b0;
  logic        rand_ready = 1'b0;
  logic [7:0]  exp_q [$];
  logic [31:0] model_mem [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // tx_ready changes just after each rising edge
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor: pops the scoreboard on every accepted byte
  initial begin : monitor
    logic       hold_prev, prev_valid, prev_acc;
    logic [7:0] prev_data, exp_b;
    hold_prev = 1'b0; prev_valid = 1'b0; prev_acc = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (hold_prev) chk("tx_data_stable", 32'(tx_data), 32'(prev_data));
        if (prev_valid && !prev_acc) chk("tx_valid_hold", 32'(tx_valid), 32'd1);
        if (tx_valid && tx_ready) begin
          chk("pop_avail", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            chk("stream_byte", 32'(tx_data), 32'(exp_b));
          end
          bytes_seen++;
          last_byte = tx_data;
          last_acc_edge = cyc + 1;
        end
        hold_prev  = tx_valid && !tx_ready;
        prev_valid = tx_valid;
        prev_acc   = tx_valid && tx_ready;
        prev_data  = tx_data;
      end else begin
        hold_prev = 1'b0; prev_valid = 1'b0; prev_acc = 1'b0;
        bytes_seen = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_all(input bit nonzero);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      we = 1'b1;
      address = 8'(i);
      data = nonzero ? ((i == 0) ? 32'h12345678 : 32'h0) : 32'(i);
      model_mem[i] = data;
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  // Build the expected byte stream from the model buffer
  task automatic push_frame();
    logic [7:0] cs, b;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_q.push_back(SYNC0);
    exp_q.push_back(SYNC1);
    cs = 8'h00;
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = model_mem[w][31 - 8*k -: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
    mon_en = 1'b1;
  endtask

  task automatic wait_done(input logic [15:0] exp_fc, input bit inject);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 6000 && !done; k++) begin
      @(negedge clk);
      if (inject && k == 100) begin
        we = 1'b1; address = 8'd0; data = model_mem[0];
      end else if (inject && k == 101) begin
        we = 1'b0;
      end else if (inject && k == 104) begin
        chk("overrun_set", 32'(overrun), 32'd1);
      end
      if (handshakePC == handshakeFPGA) done = 1'b1;
    end
    chk("frame_done", 32'(done), 32'd1);
    if (done) begin
      chk("hpc_after_csum", 32'(cyc), 32'(last_acc_edge + 1));
      chk("valid_low_end", 32'(tx_valid), 32'd0);
      chk("byte_count", 32'(bytes_seen), 32'd1027);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("frame_count", 32'(frame_count), 32'(exp_fc));
      chk("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_frame(input logic [15:0] exp_fc, input bit inject);
    push_frame();
    @(negedge clk);
    handshakeFPGA = ~handshakeFPGA;
    @(negedge clk);
    chk("busy_start", 32'(busy), 32'd1);
    wait_done(exp_fc, inject);
  endtask

  task automatic check_reset_values();
    chk("rst_hpc", 32'(handshakePC), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
  endtask

  initial begin
    bit seen;
    int lat, valid_cnt;
    rst_n = 1'b0; we = 1'b0; address = 8'd0; data = 32'd0; handshakeFPGA = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", 32'(busy), 32'd0);

    // basic frame
    write_all(1'b0);
    run_frame(16'd1, 1'b0);
    chk("basic_csum", 32'(last_byte), 32'h00);

    // nonzero checksum
    write_all(1'b1);
    run_frame(16'd2, 1'b0);
    chk("nonzero_csum", 32'(last_byte), 32'h08);

    // backpressure
    write_all(1'b0);
    rand_ready = 1'b1;
    run_frame(16'd3, 1'b0);
    rand_ready = 1'b0;
    chk("bp_csum", 32'(last_byte), 32'h00);

    // overrun during DATA, then one more frame
    chk("overrun_clear", 32'(overrun), 32'd0);
    run_frame(16'd4, 1'b1);
    run_frame(16'd5, 1'b0);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // reset mid-frame
    push_frame();
    @(negedge clk);
    handshakeFPGA = ~handshakeFPGA;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (bytes_seen >= 500) seen = 1'b1;
    end
    chk("reach_500", 32'(seen), 32'd1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    handshakeFPGA = 1'b1;
    push_frame();                 // RAM keeps its contents across reset
    #2;
    rst_n = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 4 && !seen; k++) begin
      @(negedge clk);
      lat = k;
      if (tx_valid) seen = 1'b1;
    end
    chk("restart_seen", 32'(seen), 32'd1);
    chk("restart_by_2", 32'(lat <= 2), 32'd1);
    chk("restart_sync0", 32'(tx_data), 32'(SYNC0));
    wait_done(16'd1, 1'b0);

    // back-to-back frames from a clean reset
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    handshakeFPGA = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);
    for (int f = 1; f <= 3; f++) run_frame(16'(f), 1'b0);
    chk("b2b_count", 32'(frame_count), 32'd3);
    chk("b2b_hs_equal", 32'(handshakePC), 32'(handshakeFPGA));
    valid_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_valid || busy) valid_cnt++;
    end
    chk("no_spurious_start", 32'(valid_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_readout.md
# frame_readout

Downstream consumer of the frame data generator. Holds a 256 x 32-bit frame buffer written through the generator's `we`/`address`/`data` port. When the generator signals a completed frame by toggling `handshakeFPGA`, the block serialises the frame as a byte stream toward the PC link: sync header, 1024 data bytes, XOR checksum. It then toggles `handshakePC` to release the buffer for the next frame.

## Interface
Parameters:
- `SYNC0`, default 8'hA5: first header byte.
- `SYNC1`, default 8'h5A: second header byte.

Ports:
- `clk`  in  1  single system clock; everything is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `we`  in  1  buffer write enable from the generator.
- `address`  in  8  buffer write address.
- `data`  in  32  buffer write data.
- `handshakeFPGA`  in  1  frame-ready toggle from the generator.
- `handshakePC`  out  1  frame-consumed toggle back to the generator.
- `tx_data`  out  8  byte to the PC link.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  PC link accepts the byte this cycle.
- `busy`  out  1  high whenever state is not IDLE.
- `overrun`  out  1  sticky error: a write arrived while busy.
- `frame_count`  out  16  number of completed frames; wraps at 16'hFFFF -> 0.

## Operation
- **Buffer**
  - 256 x 32 RAM, synchronous write, synchronous read with 1-cycle latency.
  - Writes are always performed, busy or not.
  - The RAM is not cleared by reset.
- **Frame-ready condition:** `handshakeFPGA != handshakePC`. Both signals are in the `clk` domain, so no synchroniser is used.
- **States**
  - IDLE: if the frame-ready condition holds, go to HDR0 and issue a read of address 0; otherwise stay.
  - HDR0: present `SYNC0`; on acceptance go to HDR1.
  - HDR1: present `SYNC1`; on acceptance go to DATA with byte index 0 and word index 0.
  - DATA: present byte `[31:24]`, `[23:16]`, `[15:8]`, `[7:0]` of the current word, in that order (MSB first).
    - After byte 3 is accepted, word index +1.
    - After word 255 byte 3 is accepted, go to CSUM.
    - The next word is prefetched so there are no bubbles when `tx_ready` is held high.
  - CSUM: present the XOR of all 1024 data bytes. Header bytes are excluded. The checksum accumulator is cleared on entry to HDR0. On acceptance go to DONE.
  - DONE: one cycle. `handshakePC <= handshakeFPGA`, `frame_count` +1, then IDLE.
- **Acceptance** means `tx_valid && tx_ready` in the same cycle.
  - While `tx_valid=1 && tx_ready=0`, `tx_data` must stay stable.
  - `tx_valid` never drops without acceptance.
- **Overrun:** `we=1` while `busy=1` sets `overrun`.
  - The write still lands in the RAM, so the frame may be corrupted.
  - `overrun` is cleared only by reset.
- **Extra toggle:** a toggle of `handshakeFPGA` during a readout is not queued separately. In DONE, `handshakePC` copies the current `handshakeFPGA`, so a double toggle is absorbed.
- **Reset values:** `handshakePC=0`, `tx_valid=0`, `tx_data=8'h00`, `busy=0`, `overrun=0`, `frame_count=0`, state IDLE, checksum 0.
- **Reset mid-frame:** the readout is aborted immediately. After release, if `handshakeFPGA=1`, a new readout of the stale RAM contents starts.

## Timing
- Frame-ready condition true at edge t: state HDR0 after edge t; `tx_valid=1` with `tx_data=SYNC0` from t+1.
- With `tx_ready` held high: one byte per cycle, 1027 bytes on cycles t+1 … t+1027.
  - DONE at t+1028.
  - `handshakePC` toggles after edge t+1028.
  - Back in IDLE at t+1029.
  - A new frame is detected at the earliest at t+1029.
- `tx_valid` is low in IDLE and DONE.
- Backpressure stretches the readout 1:1. No bytes are lost or duplicated.
- The write port has no latency restriction. A write to address A followed by a read of A one cycle later returns the new data.

## Test plan
- **Basic frame.** Write 0x00000000..0x000000FF to addresses 0..255, toggle `handshakeFPGA`, `tx_ready=1`.
  - Stream: A5, 5A, then for each word n: 00 00 00 n.
  - Checksum 0x00. Exactly 1027 bytes.
  - `handshakePC` toggles 1 cycle after the checksum is accepted; `frame_count=1`.
- **Nonzero checksum.** Word 0 = 0x12345678, all other words 0.
  - Data starts 12 34 56 78.
  - Checksum 0x08.
- **Backpressure.** Random `tx_ready` (about 50%), same data as the basic frame.
  - Byte sequence identical to the basic frame.
  - `tx_data` stable whenever valid and not ready.
  - No gap in `tx_valid` until DONE.
- **Overrun.** Assert `we` once during DATA.
  - `overrun` goes to 1 and stays 1 through the next frame.
  - `frame_count` still increments.
- **Reset mid-frame.** Pull `rst_n` low after 500 bytes.
  - All outputs go to their reset values asynchronously.
  - With `handshakeFPGA=1` at release, a fresh A5 is sent 2 cycles after release.
- **Back-to-back frames.** Three toggles of `handshakeFPGA`, each after the previous `handshakePC` toggle.
  - `frame_count=3`; `handshakePC` ends equal to `handshakeFPGA`.
  - No readout starts while the two handshake signals are equal.
